// File: rtl/mvma_host_port_pkg.sv
// rtl/mvma_host_port_pkg.sv - shared sizes and state type for the MAC accelerator host port
package mvma_host_port_pkg;

   localparam int NROWS_A     = 3;
   localparam int NCOLS_A     = 3;
   localparam int NROWS_B     = 3;
   localparam int NCOLS_B     = 1;

   localparam int FRAME_SIZE  = NROWS_A * NCOLS_A + 2 * NROWS_B * NCOLS_B;
   localparam int NUM_OUT     = NROWS_A * NCOLS_B;
   localparam int FRAME_LSIZE = $clog2(FRAME_SIZE);
   localparam int RES_LSIZE   = $clog2(NUM_OUT);
   localparam int OVF_W       = $clog2(NUM_OUT + 1);
   localparam int TXC_W       = $clog2(FRAME_SIZE + 1);
   localparam int RXC_W       = $clog2(NUM_OUT + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} host_state_t;

endpackage

// File: rtl/mvma_host_port_mem.sv
// rtl/mvma_host_port_mem.sv - single-port-write, registered-read buffer
// Out-of-range writes are dropped and out-of-range reads return 0.
module mvma_host_port_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 15,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i && (int'(waddr_i) < DEPTH)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read samples the array before this cycle's write lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_o <= '0;
      end else if (int'(raddr_i) < DEPTH) begin
         rdata_o <= mem_q[raddr_i];
      end else begin
         rdata_o <= '0;
      end
   end

endmodule

// File: rtl/mvma_host_port.sv
// rtl/mvma_host_port.sv - host port: streams one frame to the MAC accelerator and buffers its results
module mvma_host_port
   import mvma_host_port_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_wr_en,
   input  logic [FRAME_LSIZE-1:0] cfg_addr,
   input  logic signed [7:0]      cfg_wdata,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   input  logic [RES_LSIZE-1:0]   res_addr,
   output logic signed [15:0]     res_data,
   output logic                   res_ovf,
   output logic [OVF_W-1:0]       ovf_count,
   output logic signed [7:0]      tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   input  logic signed [15:0]     rx_data,
   input  logic                   rx_valid,
   input  logic                   rx_overflow,
   output logic                   rx_ready,
   input  logic                   rx_stall
);

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   host_state_t      state_q;
   logic             busy_q, done_q, err_q, tx_valid_q;
   logic [7:0]       tx_data_q;
   logic [TXC_W-1:0] tx_cnt_q;
   logic [RXC_W-1:0] rx_cnt_q;
   logic [OVF_W-1:0] ovf_q;
   logic [WD_W-1:0]  wd_q;

   logic                   tx_fire, rx_fire, complete, timeout;
   logic [FRAME_LSIZE-1:0] frame_raddr_d;
   logic [7:0]             frame_rdata;
   logic [16:0]            res_rdata;

   assign tx_fire  = tx_valid_q && tx_ready;
   assign rx_ready = (state_q == RUN) && !rx_stall && (rx_cnt_q < RXC_W'(NUM_OUT));
   assign rx_fire  = rx_valid && rx_ready;
   assign complete = (tx_cnt_q == TXC_W'(FRAME_SIZE)) && (rx_cnt_q == RXC_W'(NUM_OUT));
   assign timeout  = !tx_fire && !rx_fire && (wd_q == WD_W'(TIMEOUT_CYC - 1));

   // Keep the read port one byte ahead of tx_data so a handshake can reload it at once.
   always_comb begin
      frame_raddr_d = '0;
      if (state_q == IDLE && start) begin
         frame_raddr_d = FRAME_LSIZE'(1);
      end else if (state_q == RUN) begin
         frame_raddr_d = tx_fire ? FRAME_LSIZE'(tx_cnt_q + TXC_W'(2))
                                 : FRAME_LSIZE'(tx_cnt_q + TXC_W'(1));
      end
   end

   mvma_host_port_mem #(.WIDTH(8), .DEPTH(FRAME_SIZE), .AW(FRAME_LSIZE)) u_frame (
      .clk     (clk),
      .reset   (reset),
      .we_i    (cfg_wr_en && (state_q != RUN)),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_wdata),
      .raddr_i (frame_raddr_d),
      .rdata_o (frame_rdata)
   );

   mvma_host_port_mem #(.WIDTH(17), .DEPTH(NUM_OUT), .AW(RES_LSIZE)) u_result (
      .clk     (clk),
      .reset   (reset),
      .we_i    (rx_fire),
      .waddr_i (RES_LSIZE'(rx_cnt_q)),
      .wdata_i ({rx_overflow, rx_data}),
      .raddr_i (res_addr),
      .rdata_o (res_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
         ovf_q      <= '0;
         wd_q       <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= RUN;
                  busy_q     <= 1'b1;
                  err_q      <= 1'b0;
                  ovf_q      <= '0;
                  tx_cnt_q   <= '0;
                  rx_cnt_q   <= '0;
                  wd_q       <= '0;
                  tx_data_q  <= frame_rdata;
                  tx_valid_q <= 1'b1;
               end
            end
            RUN: begin
               if (tx_fire) begin
                  tx_cnt_q <= tx_cnt_q + TXC_W'(1);
                  if (tx_cnt_q == TXC_W'(FRAME_SIZE - 1)) begin
                     tx_valid_q <= 1'b0;
                  end else begin
                     tx_data_q <= frame_rdata;
                  end
               end
               if (rx_fire) begin
                  rx_cnt_q <= rx_cnt_q + RXC_W'(1);
                  if (rx_overflow) begin
                     ovf_q <= ovf_q + OVF_W'(1);
                  end
               end
               wd_q <= (tx_fire || rx_fire) ? '0 : wd_q + WD_W'(1);
               if (complete || timeout) begin
                  state_q    <= DONE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  tx_valid_q <= 1'b0;
                  err_q      <= !complete;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign ovf_count = ovf_q;
   assign res_data  = res_rdata[15:0];
   assign res_ovf   = res_rdata[16];

endmodule

// File: tb/tb_mvma_host_port.sv
// tb/tb_mvma_host_port.sv - scoreboard bench for the MAC accelerator host port
module tb_mvma_host_port;
   import mvma_host_port_pkg::*;

   localparam int TO = 16;

   logic                   clk = 1'b0;
   logic                   reset, cfg_wr_en, start, tx_ready, rx_valid, rx_overflow, rx_stall;
   logic [FRAME_LSIZE-1:0] cfg_addr;
   logic [7:0]             cfg_wdata;
   logic [RES_LSIZE-1:0]   res_addr;
   logic [15:0]            rx_data;
   logic                   busy, done, err, res_ovf, tx_valid, rx_ready;
   logic [15:0]            res_data;
   logic [OVF_W-1:0]       ovf_count;
   logic [7:0]             tx_data;

   always #5 clk = ~clk;

   mvma_host_port #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .start(start), .busy(busy), .done(done), .err(err), .res_addr(res_addr), .res_data(res_data),
      .res_ovf(res_ovf), .ovf_count(ovf_count), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_overflow(rx_overflow),
      .rx_ready(rx_ready), .rx_stall(rx_stall)
   );

   int          errors = 0, checks = 0;
   int          cyc = 0;
   logic [7:0]  tx_exp[$];
   logic [16:0] rd_exp[$];
   logic        rd_req = 1'b0, rd_vld = 1'b0;
   int          tx_fires = 0, first_fire_cyc = 0, last_fire_cyc = 0, done_cnt = 0, done_cyc = 0;
   logic        hold_chk = 1'b0, low_chk = 1'b0;
   logic [7:0]  hold_data;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rd_vld <= rd_req;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every tx handshake and every result read pops the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         hold_chk = 1'b0;
         low_chk  = 1'b0;
      end else begin
         if (hold_chk) begin
            check("tx_hold_valid", tx_valid, 1);
            check("tx_hold_data", tx_data, hold_data);
         end
         if (low_chk) check("tx_valid_after_last", tx_valid, 0);
         hold_chk = 1'b0;
         low_chk  = 1'b0;
         if (start && !busy) tx_fires = 0;
         if (tx_valid && tx_ready) begin
            if (tx_exp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_extra_byte: actual=%0h required=none", tx_data);
            end else begin
               check("tx_data", tx_data, tx_exp.pop_front());
            end
            if (tx_fires == 0) first_fire_cyc = cyc;
            tx_fires++;
            last_fire_cyc = cyc;
            if (tx_fires == FRAME_SIZE) low_chk = 1'b1;
         end else if (tx_valid) begin
            hold_chk  = 1'b1;
            hold_data = tx_data;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (rd_vld) begin
            if (rd_exp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_extra: actual=%0h required=none", res_data);
            end else begin
               logic [16:0] e;
               e = rd_exp.pop_front();
               check("res_data", res_data, e[15:0]);
               check("res_ovf", res_ovf, e[16]);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int a, input logic [7:0] v);
      cfg_addr  = FRAME_LSIZE'(a);
      cfg_wdata = v;
      cfg_wr_en = 1'b1;
      tick();
      cfg_wr_en = 1'b0;
   endtask

   task automatic rd_check(input int a, input logic [15:0] d, input logic o);
      rd_exp.push_back({o, d});
      res_addr = RES_LSIZE'(a);
      rd_req   = 1'b1;
      tick();
      rd_req = 1'b0;
      tick();
   endtask

   task automatic respond(input logic [15:0] d, input logic o, input int stall);
      bit ok = 0;
      rx_data     = d;
      rx_overflow = o;
      rx_valid    = 1'b1;
      if (stall > 0) begin
         rx_stall = 1'b1;
         repeat (stall) begin
            @(negedge clk);
            check("rx_ready_stalled", rx_ready, 0);
            tick();
         end
         rx_stall = 1'b0;
      end
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (rx_ready) ok = 1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL rx_handshake_timeout: actual=no_ready required=ready");
      end
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic push_frame();
      for (int i = 1; i <= FRAME_SIZE; i++) tx_exp.push_back(8'(i));
   endtask

   // mode 0: tx_ready held high; mode 1: tx_ready toggles 1,0,1,0...
   task automatic run(input int mode, input logic [15:0] r0, input logic [15:0] r1,
                      input logic [15:0] r2, input logic o1, input int stall, input bit inject);
      int d0 = done_cnt;
      push_frame();
      tx_ready = 1'b1;
      start    = 1'b1;
      tick();
      start = 1'b0;
      fork
         begin
            for (int i = 0; i < 400 && done_cnt == d0; i++) begin
               tick();
               if (mode == 1) tx_ready = ~tx_ready;
            end
         end
         begin
            tick(2);
            respond(r0, 1'b0, 0);
            respond(r1, o1, stall);
            respond(r2, 1'b0, 0);
         end
         begin
            if (inject) begin
               tick(4);
               start = 1'b1;
               cfg_write(0, 8'h7F);
               start = 1'b0;
            end
         end
      join
      tick(3);
      check("done_once", done_cnt - d0, 1);
      check("err_after_run", err, 0);
      check("busy_after_run", busy, 0);
      check("tx_all_sent", tx_exp.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: actual=hung required=finished");
      $fatal(1);
   end

   initial begin
      int d0;
      reset = 1'b1; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_overflow = 1'b0; rx_stall = 1'b0;
      rx_data = '0; res_addr = '0;
      tick(3);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_rx_ready", rx_ready, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_ovf", res_ovf, 0);
      check("rst_ovf_count", ovf_count, 0);
      tick();

      for (int i = 0; i < FRAME_SIZE; i++) cfg_write(i, 8'(i + 1));
      cfg_write(FRAME_SIZE, 8'hEE);
      tick(2);

      // Back-to-back stream plus results with a stalled second response.
      run(0, 16'h0102, 16'hFF00, 16'h0506, 1'b1, 4, 1'b0);
      check("consecutive_tx", last_fire_cyc - first_fire_cyc, FRAME_SIZE - 1);
      check("ovf_count_run1", ovf_count, 1);
      rd_check(0, 16'h0102, 1'b0);
      rd_check(1, 16'hFF00, 1'b1);
      rd_check(2, 16'h0506, 1'b0);
      rd_check(3, 16'h0000, 1'b0);

      // Toggling tx_ready: one transfer every other cycle.
      run(1, 16'h7FFF, 16'h8000, 16'h0001, 1'b0, 0, 1'b0);
      check("toggle_tx_span", last_fire_cyc - first_fire_cyc, 2 * (FRAME_SIZE - 1));
      check("ovf_count_run2", ovf_count, 0);
      rd_check(1, 16'h8000, 1'b0);

      // Accelerator never answers: watchdog abort 16 edges after the last byte.
      d0 = done_cnt;
      push_frame();
      tx_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
      check("timeout_done", done_cnt - d0, 1);
      check("timeout_latency", done_cyc - last_fire_cyc, TO + 1);
      check("timeout_err", err, 1);
      check("timeout_tx_all_sent", tx_exp.size(), 0);
      tick();
      check("timeout_busy", busy, 0);
      check("timeout_tx_valid", tx_valid, 0);
      check("timeout_rx_ready", rx_ready, 0);
      tick(2);

      // start and cfg write mid-RUN are ignored.
      run(0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 0, 1'b1);
      rd_check(2, 16'h3333, 1'b0);

      // Reset after the 7th byte, then a fresh run must resend from byte 0.
      push_frame();
      tx_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      respond(16'h4000, 1'b1, 0);
      for (int i = 0; i < 60 && tx_fires < 7; i++) @(negedge clk);
      tick();
      check("pre_reset_ovf_count", ovf_count, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("reset_tx_valid", tx_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_ovf_count", ovf_count, 0);
      check("reset_rx_ready", rx_ready, 0);
      tx_exp.delete();
      tick(2);
      run(0, 16'h0A0B, 16'h0C0D, 16'h0E0F, 1'b0, 0, 1'b0);
      rd_check(0, 16'h0A0B, 1'b0);
      rd_check(2, 16'h0E0F, 1'b0);

      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
